tone_bank: RTL and testbench
============================

TONE_BANK -- requirements
Module: tone_bank

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of independent square-wave channels (1..8).
REQ-002 SHALL have parameter FREQ_W, default 10, width of each channel's half-period register.
REQ-003 SHALL have parameter CH_W, default 2, width of the channel-select field; 2^CH_W >= N_CH.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port tone_clk  input  1  single-cycle advance strobe, synchronous to clk.
REQ-007 SHALL have port wr_en  input  1  one-cycle frequency write request.
REQ-008 SHALL have port wr_ch  input  CH_W  target channel of the write.
REQ-009 SHALL have port wr_freq  input  FREQ_W  new half-period value, in tone_clk ticks.
REQ-010 SHALL have port pending  output  N_CH  bit i high while channel i holds a written but not yet applied value.
REQ-011 SHALL have port tone_out  output  N_CH  bit i is the square wave of channel i.

Function
REQ-012 SHALL keep per channel: counter cnt[FREQ_W], active period act[FREQ_W], pending value pnd[FREQ_W], pending flag, output bit.
REQ-013 SHALL, on a clk edge with wr_en=1 and wr_ch<N_CH, load pnd[wr_ch]<=wr_freq and set pending[wr_ch] on the next edge.
REQ-014 SHALL ignore writes with wr_ch>=N_CH, leaving all state unchanged.
REQ-015 SHALL, when a second write to the same channel precedes the apply, overwrite pnd; only the last value is applied.
REQ-016 SHALL advance counters only on clk edges with tone_clk=1; with tone_clk=0, cnt, act and tone_out hold.
REQ-017 SHALL define effective period P = act, with act=0 treated as 2^FREQ_W.
REQ-018 SHALL, on an advancing edge, wrap when cnt >= P-1: cnt<=0 and tone_out toggles on that same edge. Otherwise cnt<=cnt+1.
REQ-019 SHALL make each half-period exactly P tone_clk ticks, giving a full period of 2*P ticks.
REQ-020 SHALL apply a pending value only on a wrap edge: act<=pnd and the pending flag clears, so no half-period is ever truncated (glitch-free retune).
REQ-021 SHALL, when a write and a wrap for the same channel occur on the same edge, use the pre-edge pnd for that wrap (applied only if pending was already set). The new write stays pending until the following wrap.
REQ-022 SHALL update every channel in parallel on each advancing edge; no channel affects another.
REQ-023 SHALL make tone_out and pending registered outputs with no combinational path from inputs.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force every cnt=0, act=0, pnd=0, pending=0 and tone_out=0.
REQ-025 SHALL, on reset mid-half-period, discard the partial count and any pending write. After release, the first toggle occurs after P=2^FREQ_W ticks, unless a write is applied first by a wrap.
REQ-026 SHALL ignore tone_clk and wr_en on the edge where reset_n is sampled low.

Configuration
REQ-027 SHALL support macro TONE_BANK_FREQ_HOLD_EN.
REQ-028 SHALL, with TONE_BANK_FREQ_HOLD_EN defined, force tone_out[i]=1 and hold cnt[i]=0 while act[i] is 0 or 1. Pending values are then applied on the next advancing edge, so a hold channel can be re-tuned (for sample playback).
REQ-029 SHALL, without TONE_BANK_FREQ_HOLD_EN, treat act=1 as toggle-every-tick and act=0 as 2^FREQ_W per REQ-017.

Verification
REQ-030 SHALL check: reset, tone_clk=1 every cycle, write ch0=4 -> applied at first wrap (tick 1024), then tone_out[0] toggles every 4 cycles (period 8).
REQ-031 SHALL check: ch1 running at 10, write 3 at tick 5 of a half-period -> that half completes at 10 ticks, then 3-tick halves; pending[1] high for exactly 5 ticks.
REQ-032 SHALL check: tone_clk=1 once every 4 clk, ch2 at 2 -> tone_out[2] toggles every 8 clk; holding tone_clk=0 freezes tone_out and cnt.
REQ-033 SHALL check: write wr_ch=3 with N_CH=3 -> no pending bit set, all outputs unchanged.
REQ-034 SHALL check: write coincident with wrap edge -> old value used, new value applied at the next wrap; reset_n pulsed low mid-period -> all outputs 0 at once.
REQ-035 SHALL check: with TONE_BANK_FREQ_HOLD_EN, write ch0=1 -> tone_out[0] constant 1; write 5 -> toggling resumes with 5-tick halves.

Source files
------------

// File: rtl/tone_bank.sv
// tone_bank: bank of N_CH independent square-wave generators.
// Each channel counts tone_clk strobes and toggles its output every P
// strobes, where P is the active half-period (0 means 2^FREQ_W).
// New half-periods are written into a per-channel pending slot and are
// taken over only on a wrap edge, so a running half-period is never cut
// short.
// Optional feature macro: TONE_BANK_FREQ_HOLD_EN. When it is defined, a
// channel whose active period is 0 or 1 holds its output high with the
// counter parked at 0. Its pending value is then taken on the next
// advancing edge, which lets sample playback re-tune a held channel.
module tone_bank #(
    parameter int N_CH   = 3,
    parameter int FREQ_W = 10,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tone_clk,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [FREQ_W-1:0] wr_freq,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   tone_out
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [FREQ_W-1:0] cnt_q, cnt_d;
        logic [FREQ_W-1:0] act_q, act_d;
        logic [FREQ_W-1:0] pnd_q, pnd_d;
        logic              pend_q, pend_d;
        logic              tone_q, tone_d;
        logic [FREQ_W:0]   last_cnt;
        logic              wrap;
        logic              wr_sel;

        // A write to a channel index that does not exist matches no channel
        // and is therefore dropped.
        assign wr_sel = wr_en && (32'(wr_ch) == 32'(gi));

        // Last count value of a half-period: P-1, with act=0 meaning 2^FREQ_W.
        assign last_cnt = (act_q == '0) ? {1'b0, {FREQ_W{1'b1}}}
                                        : {1'b0, act_q} - (FREQ_W+1)'(1);
        assign wrap     = tone_clk && ({1'b0, cnt_q} >= last_cnt);

        // Next-state: advance/wrap on tone_clk, retune on wrap, capture writes.
        always_comb begin
            cnt_d  = cnt_q;
            act_d  = act_q;
            pnd_d  = pnd_q;
            pend_d = pend_q;
            tone_d = tone_q;
`ifdef TONE_BANK_FREQ_HOLD_EN
            if (act_q[FREQ_W-1:1] == '0) begin
                // Hold channel: output pinned high, retune on any strobe.
                cnt_d  = '0;
                tone_d = 1'b1;
                if (tone_clk && pend_q) begin
                    act_d  = pnd_q;
                    pend_d = 1'b0;
                end
            end else if (tone_clk) begin
`else
            if (tone_clk) begin
`endif
                if (wrap) begin
                    cnt_d  = '0;
                    tone_d = ~tone_q;
                    // Only a value that was already pending before this edge
                    // is taken; a write on this same edge waits one wrap.
                    if (pend_q) begin
                        act_d  = pnd_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + FREQ_W'(1);
                end
            end
            // A write overrides the pending slot last so it always survives.
            if (wr_sel) begin
                pnd_d  = wr_freq;
                pend_d = 1'b1;
            end
        end

        // Channel state register with asynchronous clear.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                act_q  <= '0;
                pnd_q  <= '0;
                pend_q <= 1'b0;
                tone_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                pnd_q  <= pnd_d;
                pend_q <= pend_d;
                tone_q <= tone_d;
            end
        end

        assign pending[gi]  = pend_q;
        assign tone_out[gi] = tone_q;
    end

endmodule

// File: tb/tb_tone_bank.sv
// Testbench for tone_bank: vector table, directed corner sequences and a
// randomized run checked against a tick-counting reference model.
module tb_tone_bank;
    localparam int N_CH   = 3;
    localparam int FREQ_W = 10;
    localparam int CH_W   = 2;
    localparam int PMAX   = 1 << FREQ_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              tone_clk = 1'b0;
    logic              wr_en = 1'b0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [FREQ_W-1:0] wr_freq = '0;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   tone_out;

    int vectors = 0;
    int errors  = 0;

    tone_bank #(.N_CH(N_CH), .FREQ_W(FREQ_W), .CH_W(CH_W)) dut (
        .clk(clk), .reset_n(reset_n), .tone_clk(tone_clk),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_freq(wr_freq),
        .pending(pending), .tone_out(tone_out)
    );

    always #5 clk = ~clk;

    // Reference model: ticks elapsed in the current half-period, compared
    // against the effective period after each strobe.
    int m_act[N_CH];
    int m_pnd[N_CH];
    int m_el[N_CH];
    bit m_pend[N_CH];
    bit m_tone[N_CH];

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_act[i] = 0; m_pnd[i] = 0; m_el[i] = 0; m_pend[i] = 0; m_tone[i] = 0;
        end
    endtask

    task automatic model_edge(input bit tc, input bit we, input int ch, input int f);
        for (int i = 0; i < N_CH; i++) begin
            int p;
            p = (m_act[i] == 0) ? PMAX : m_act[i];
`ifdef TONE_BANK_FREQ_HOLD_EN
            if (m_act[i] <= 1) begin
                m_el[i] = 0;
                m_tone[i] = 1;
                if (tc && m_pend[i]) begin
                    m_act[i] = m_pnd[i];
                    m_pend[i] = 0;
                end
            end else
`endif
            if (tc) begin
                m_el[i] = m_el[i] + 1;
                if (m_el[i] == p) begin
                    m_el[i] = 0;
                    m_tone[i] = !m_tone[i];
                    if (m_pend[i]) begin
                        m_act[i] = m_pnd[i];
                        m_pend[i] = 0;
                    end
                end
            end
        end
        if (we && ch < N_CH) begin
            m_pnd[ch] = f;
            m_pend[ch] = 1;
        end
    endtask

    function automatic logic [N_CH-1:0] m_tone_vec();
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = m_tone[i];
        return v;
    endfunction

    function automatic logic [N_CH-1:0] m_pend_vec();
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [FREQ_W-1:0] got, input logic [FREQ_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clk cycle: inputs driven now, outputs sampled 1 ns after the edge.
    task automatic tick(input bit tc, input bit we, input int ch, input int f);
        tone_clk = tc;
        wr_en    = we;
        wr_ch    = CH_W'(ch);
        wr_freq  = FREQ_W'(f);
        @(posedge clk);
        if (reset_n) model_edge(tc, we, ch, f);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        tick(0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0);
    endtask

    typedef struct {
        bit              we;
        int              ch;
        int              f;
        logic [N_CH-1:0] exp_pend;
        logic [N_CH-1:0] exp_tone;
    } vec_t;

`ifdef TONE_BANK_FREQ_HOLD_EN
    localparam logic [N_CH-1:0] IDLE_TONE = '1;
`else
    localparam logic [N_CH-1:0] IDLE_TONE = '0;
`endif

    initial begin
        vec_t tbl[6];
        int t;
        bit tc;
        logic [N_CH-1:0] e_tone;

        // Write-path table, tone_clk held low throughout.
        tbl[0] = '{1, 3, 5, 3'b000, IDLE_TONE};
        tbl[1] = '{1, 0, 4, 3'b001, IDLE_TONE};
        tbl[2] = '{1, 2, 7, 3'b101, IDLE_TONE};
        tbl[3] = '{1, 1, 2, 3'b111, IDLE_TONE};
        tbl[4] = '{1, 3, 9, 3'b111, IDLE_TONE};
        tbl[5] = '{0, 0, 0, 3'b111, IDLE_TONE};

        reset_n = 1'b0;
        model_reset();
        #3;
        chk("reset_pending", FREQ_W'(pending), '0);
        chk("reset_tone", FREQ_W'(tone_out), '0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tick(0, tbl[i].we, tbl[i].ch, tbl[i].f);
            $display("vec %0d: we=%0d ch=%0d f=%0d pending=%b tone=%b", i,
                     tbl[i].we, tbl[i].ch, tbl[i].f, pending, tone_out);
            chk("tbl_pending", FREQ_W'(pending), FREQ_W'(tbl[i].exp_pend));
            chk("tbl_tone", FREQ_W'(tone_out), FREQ_W'(tbl[i].exp_tone));
        end

`ifndef TONE_BANK_FREQ_HOLD_EN
        // ch0 = 4 applied at tick 1024, then 4-tick halves.
        do_reset();
        for (int k = 1; k <= 1040; k++) begin
            tick(1, k == 1, 0, 4);
            chk("r030_tone0", FREQ_W'(tone_out[0]),
                FREQ_W'((k < 1024) ? 0 : ((((k - 1024) / 4) % 2 == 0) ? 1 : 0)));
            chk("r030_pend0", FREQ_W'(pending[0]), FREQ_W'(k < 1024));
        end
        $display("seq ch0=4 apply/period done");

        // Retune mid-half: 10-tick half completes, then 3-tick halves.
        do_reset();
        tick(0, 1, 1, 10);
        run_ticks(PMAX);
        chk("r031_applied_tone1", FREQ_W'(tone_out[1]), FREQ_W'(1));
        for (int k = 1; k <= 20; k++) begin
            tick(1, k == 5, 1, 3);
            chk("r031_tone1", FREQ_W'(tone_out[1]),
                FREQ_W'((k < 10) ? 1 : ((((k - 10) / 3) % 2 == 0) ? 0 : 1)));
            chk("r031_pend1", FREQ_W'(pending[1]), FREQ_W'(k >= 5 && k < 10));
        end
        $display("seq ch1 retune 10->3 done");

        // Sparse tone_clk and freeze window on ch2 at 2.
        do_reset();
        tick(0, 1, 2, 2);
        run_ticks(PMAX);
        chk("r032_applied_tone2", FREQ_W'(tone_out[2]), FREQ_W'(1));
        t = 0;
        for (int c = 1; c <= 80; c++) begin
            tc = (c % 4 == 0) && !(c > 44 && c <= 64);
            tick(tc, 0, 0, 0);
            if (tc) t++;
            chk("r032_tone2", FREQ_W'(tone_out[2]), FREQ_W'(((t / 2) % 2 == 0) ? 1 : 0));
        end
        $display("seq ch2 sparse strobe/freeze done");

        // Write on the wrap edge, then asynchronous reset mid-period.
        do_reset();
        tick(0, 1, 0, 3);
        run_ticks(PMAX);
        for (int k = 1; k <= 20; k++) begin
            tick(1, k == 3, 0, 6);
            chk("r034_tone0", FREQ_W'(tone_out[0]),
                FREQ_W'((k < 3) ? 1 : (k < 6) ? 0 : ((((k - 6) / 6) % 2 == 0) ? 1 : 0)));
            chk("r034_pend0", FREQ_W'(pending[0]), FREQ_W'(k >= 3 && k < 6));
        end
        tick(0, 1, 1, 7);
        chk("r034_pre_rst_pend", FREQ_W'(pending), FREQ_W'(3'b010));
        chk("r034_pre_rst_tone", FREQ_W'(tone_out), FREQ_W'(3'b111));
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("r034_async_pend", FREQ_W'(pending), '0);
        chk("r034_async_tone", FREQ_W'(tone_out), '0);
        tick(1, 1, 0, 2);
        chk("r034_rst_edge_pend", FREQ_W'(pending), '0);
        reset_n = 1'b1;
        for (int k = 1; k <= PMAX; k++) begin
            tick(1, 0, 0, 0);
            if (k == PMAX - 1) chk("r025_no_early_toggle", FREQ_W'(tone_out), '0);
        end
        chk("r025_first_toggle", FREQ_W'(tone_out), FREQ_W'(3'b111));
        $display("seq wrap-coincident write / async reset done");
`else
        // Hold channel: period 1 pins output high, 5 resumes toggling.
        do_reset();
        tick(0, 0, 0, 0);
        chk("r035_idle_tone0", FREQ_W'(tone_out[0]), FREQ_W'(1));
        tick(1, 1, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            tick(1, 0, 0, 0);
            chk("r035_hold_tone0", FREQ_W'(tone_out[0]), FREQ_W'(1));
            chk("r035_hold_pend0", FREQ_W'(pending[0]), '0);
        end
        tick(1, 1, 0, 5);
        chk("r035_pend_set", FREQ_W'(pending[0]), FREQ_W'(1));
        for (int k = 1; k <= 22; k++) begin
            tick(1, 0, 0, 0);
            chk("r035_run_tone0", FREQ_W'(tone_out[0]),
                FREQ_W'((k < 6) ? 1 : ((((k - 6) / 5) % 2 == 0) ? 0 : 1)));
        end
        $display("seq hold channel retune done");
`endif

        // Randomized run against the reference model.
        do_reset();
        for (int n = 0; n < 6000; n++) begin
            bit we;
            int ch;
            int f;
            tc = ($urandom_range(0, 9) < 7);
            we = ($urandom_range(0, 7) == 0);
            ch = $urandom_range(0, 3);
            f  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 12);
            if ($urandom_range(0, 1999) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end
            tick(tc, we, ch, f);
            reset_n = 1'b1;
            e_tone = m_tone_vec();
            chk("rand_tone", FREQ_W'(tone_out), FREQ_W'(e_tone));
            chk("rand_pending", FREQ_W'(pending), FREQ_W'(m_pend_vec()));
        end
        $display("random run done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
